multicore_sched: RTL and testbench
==================================

# multicore_sched

Controller for the multicore array of `rede` cores. It releases each core from reset in a staggered sequence. It then arbitrates the cores' output beats round-robin onto one shared output port, with a valid/ready handshake and a per-core acknowledge. It replaces the fixed-priority output mux so that no core can starve another, and cores only need to hold a beat until it is acknowledged.

## Interface
- `N_CORES`, default 48: number of cores served.
- `DW`, default 31: signed data width per core.
- `EW`, default 4: output-enable width per core.
- `STAGGER`, default 7: cycles between successive core reset releases (≥1).
- `IW`, default `$clog2(N_CORES)`: grant index width.

- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `core_out`  in  N_CORES*DW  packed core data; core i occupies `[i*DW +: DW]`, signed.
- `core_en`  in  N_CORES*EW  packed core output-enables, slice i at `[i*EW +: EW]`.
- `core_rst`  out  N_CORES  per-core reset, active high.
- `core_ack`  out  N_CORES  one-hot, one-cycle pulse: the core's current beat was captured.
- `io_out`  out  DW  signed data of the held beat.
- `out_en`  out  EW  enable slice of the held beat.
- `out_valid`  out  1  a beat is held on `io_out` / `out_en`.
- `out_ready`  in  1  the consumer accepts the beat.
- `grant_id`  out  IW  index of the core whose beat is held.
- `seq_done`  out  1  all cores have been released from reset.

## Operation
- **Reset sequencer.** Built from a core index counter and a stagger counter.
  - Core k's `core_rst[k]` falls at edge k*STAGGER+1, counting from edge 1, the first edge with `rst`=0.
  - Once a core is released it stays released.
  - `seq_done` rises at the edge after the last core is released and stays high until `rst`.
- **Request.** `req[i] = (core_en slice i != 0) && !core_rst[i]`. Cores still in reset never request.
- **Arbiter FSM.** Two states, IDLE and HOLD.
  - IDLE, any `req`: choose the first requester searching from `last+1` mod N_CORES, with wrap-around.
    - Capture its data into `io_out` and its enable slice into `out_en`.
    - Set `grant_id`, `last` and `out_valid`=1, and move to HOLD.
    - `core_ack[i]` is 1 for exactly the cycle after the capture edge.
  - IDLE, no `req`: stay in IDLE with `out_valid`=0.
  - HOLD: hold `io_out`, `out_en` and `grant_id` stable. On an edge with `out_ready`=1, clear `out_valid` and go to IDLE.
  - HOLD ignores all requests. New requests are evaluated only in IDLE.
- **Core obligation.** A core must update or clear its enable slice at the edge where it samples `core_ack`=1.
- **Round-robin pointer.** `last` resets to N_CORES-1, so core 0 has first priority after reset.
- **Simultaneous events.**
  - Several cores request at once: only the round-robin winner is captured. The others keep requesting.
  - A core released from reset while the FSM is in HOLD is considered at the next IDLE.
- **Reset mid-operation.** `rst` at any edge:
  - Aborts the held beat and clears `out_valid`.
  - Sets every `core_rst` to 1 and restarts the sequencer from core 0.
  - Resets `last`. No `core_ack` fires.
- **Reset values.** All outputs at reset:
  - `core_rst` all ones.
  - `core_ack`, `io_out`, `out_en`, `out_valid`, `grant_id` and `seq_done` all 0.
  - FSM in IDLE.

## Timing
- Request to `out_valid`: 1 cycle (registered capture).
- Minimum beat period is 2 cycles: IDLE capture, then HOLD with `out_ready`=1.
- `core_ack` rises 1 cycle after the capture edge and coincides with the first HOLD cycle.
- Full sequence with defaults: `seq_done` rises at edge 47*7+2 = 331 after `rst` falls.
- All outputs are registered. There is no combinational path from `core_en` / `core_out` / `out_ready` to outputs.

## Test plan
- **Reset sequence.** N_CORES=48, STAGGER=7: deassert `rst`.
  - `core_rst[0]` falls at edge 1, `core_rst[1]` at edge 8, `core_rst[47]` at edge 330.
  - `seq_done` rises at edge 331.
- **Single beat.** Core 5 (released) drives `core_en`=4'd1, data -31'sd1234; `out_ready`=1.
  - `out_valid`=1 with `io_out`=-1234, `out_en`=1, `grant_id`=5.
  - `core_ack[5]` pulses once, and the beat completes in 2 cycles.
- **Round-robin fairness.** Cores 0, 3 and 47 request continuously; each re-asserts its enable after ack; `out_ready`=1.
  - Grant order is 0, 3, 47, 0, 3, 47.
  - Each core is acked exactly once per round.
- **Backpressure.** Core 2 requests; `out_ready`=0 for 10 cycles, then 1.
  - `io_out`, `out_en` and `grant_id` stay stable throughout.
  - Exactly one `core_ack[2]` pulse; `out_valid` drops the edge after `out_ready`=1.
- **Requests during reset.** All cores drive `core_en`=1 during the sequence. Only released cores are granted, and core k is never granted before `core_rst[k]`=0.
- **Reset mid-beat.** Assert `rst` while in HOLD with `grant_id`=9.
  - Next edge: `out_valid`=0 and all `core_rst`=1.
  - After `rst` falls, core 0 is released again at edge 1.

Source files
------------

// File: rtl/multicore_sched.sv
// Staggered reset release for an array of cores, followed by a round-robin
// arbiter that captures one core beat at a time onto a shared output port.
module multicore_sched #(
  parameter int N_CORES = 48,
  parameter int DW      = 31,
  parameter int EW      = 4,
  parameter int STAGGER = 7,
  parameter int IW      = $clog2(N_CORES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CORES*DW-1:0]   core_out,
  input  logic [N_CORES*EW-1:0]   core_en,
  output logic [N_CORES-1:0]      core_rst,
  output logic [N_CORES-1:0]      core_ack,
  output logic signed [DW-1:0]    io_out,
  output logic [EW-1:0]           out_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           grant_id,
  output logic                    seq_done
);

  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                state_q, state_d;
  logic [N_CORES-1:0]    core_rst_q, core_rst_d;
  logic [N_CORES-1:0]    core_ack_q, core_ack_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         stag_q, stag_d;
  logic                  seq_done_q, seq_done_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic signed [DW-1:0]  io_out_q, io_out_d;
  logic [EW-1:0]         out_en_q, out_en_d;
  logic                  valid_q, valid_d;

  logic [N_CORES-1:0]    req;
  logic [IW-1:0]         win;
  logic                  win_found;
  int                    cand;

  // Sequencer: one core leaves reset every STAGGER edges, starting with core 0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    core_rst_d = core_rst_q;
    idx_d      = idx_q;
    stag_d     = stag_q;
    seq_done_d = seq_done_q;
    if (|core_rst_q) begin
      if (stag_q == '0) begin
        core_rst_d[idx_q] = 1'b0;
        stag_d            = SW'(STAGGER - 1);
        if (idx_q != IW'(N_CORES - 1)) idx_d = idx_q + 1'b1;
      end else begin
        stag_d = stag_q - 1'b1;
      end
    end else begin
      seq_done_d = 1'b1;
    end
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    req       = '0;
    win       = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_CORES; i++)
      req[i] = (core_en[i*EW +: EW] != '0) && !core_rst_q[i];
    for (int off = 1; off <= N_CORES; off++) begin
      cand = int'(last_q) + off;
      if (cand >= N_CORES) cand = cand - N_CORES;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win       = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    core_ack_d = '0;
    last_d     = last_q;
    grant_d    = grant_q;
    io_out_d   = io_out_q;
    out_en_d   = out_en_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          io_out_d        = core_out[win*DW +: DW];
          out_en_d        = core_en[win*EW +: EW];
          grant_d         = win;
          last_d          = win;
          valid_d         = 1'b1;
          core_ack_d[win] = 1'b1;
          state_d         = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      core_rst_q <= '1;
      core_ack_q <= '0;
      idx_q      <= '0;
      stag_q     <= '0;
      seq_done_q <= 1'b0;
      last_q     <= IW'(N_CORES - 1);
      grant_q    <= '0;
      io_out_q   <= '0;
      out_en_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      core_ack_q <= core_ack_d;
      idx_q      <= idx_d;
      stag_q     <= stag_d;
      seq_done_q <= seq_done_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      io_out_q   <= io_out_d;
      out_en_q   <= out_en_d;
      valid_q    <= valid_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign core_ack  = core_ack_q;
  assign io_out    = io_out_q;
  assign out_en    = out_en_q;
  assign out_valid = valid_q;
  assign grant_id  = grant_q;
  assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_multicore_sched.sv
// Randomized bench for multicore_sched: emulated cores feed a behavioural
// model of the release schedule and round-robin arbitration, checked every cycle.
module tb_multicore_sched;

  localparam int N  = 48;
  localparam int DW = 31;
  localparam int EW = 4;
  localparam int ST = 7;
  localparam int IW = $clog2(N);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  out_ready = 1'b0;
  logic [N*DW-1:0]       core_out;
  logic [N*EW-1:0]       core_en;
  logic [N-1:0]          core_rst;
  logic [N-1:0]          core_ack;
  logic signed [DW-1:0]  io_out;
  logic [EW-1:0]         out_en;
  logic                  out_valid;
  logic [IW-1:0]         grant_id;
  logic                  seq_done;

  multicore_sched #(.N_CORES(N), .DW(DW), .EW(EW), .STAGGER(ST), .IW(IW)) dut (
    .clk(clk), .rst(rst), .core_out(core_out), .core_en(core_en),
    .core_rst(core_rst), .core_ack(core_ack), .io_out(io_out), .out_en(out_en),
    .out_valid(out_valid), .out_ready(out_ready), .grant_id(grant_id),
    .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  // Emulated cores: each holds one beat until acknowledged.
  logic [DW-1:0] c_data [N];
  logic [EW-1:0] c_en   [N];
  int            mode;  // 0 clear on ack, 1 reload random, 2 coin flip, 3 reload with en=1

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign core_out[g*DW +: DW] = c_data[g];
    assign core_en[g*EW +: EW]  = c_en[g];
  end

  // Reference model state.
  int                   n = 0;          // rst=0 edges since last reset
  bit                   m_valid = 0;
  bit                   m_in_reset = 0;
  logic signed [DW-1:0] m_data = '0;
  logic [EW-1:0]        m_en = '0;
  int                   m_gid = 0;
  int                   m_last = N - 1;
  int                   m_ack = -1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit released(input int k, input int cnt);
    return cnt >= k * ST + 1;
  endfunction

  task automatic model_edge();
    int win;
    if (rst) begin
      n = 0; m_valid = 0; m_data = '0; m_en = '0; m_gid = 0;
      m_last = N - 1; m_ack = -1; m_in_reset = 1;
    end else begin
      win = -1;
      m_in_reset = 0;
      if (m_valid) begin
        if (out_ready) m_valid = 0;
      end else begin
        for (int off = 1; off <= N; off++) begin
          int c;
          c = (m_last + off) % N;
          if (win < 0 && c_en[c] != '0 && released(c, n)) win = c;
        end
        if (win >= 0) begin
          m_valid = 1; m_data = c_data[win]; m_en = c_en[win];
          m_gid = win; m_last = win;
        end
      end
      m_ack = win;
      n++;
    end
  endtask

  task automatic compare_all();
    logic [63:0] rv, av;
    rv = '0; av = '0;
    for (int k = 0; k < N; k++) rv[k] = !released(k, n);
    if (m_ack >= 0) av[m_ack] = 1'b1;
    check("core_rst", core_rst, rv);
    check("seq_done", seq_done, n >= (N - 1) * ST + 2);
    check("out_valid", out_valid, m_valid);
    check("core_ack", core_ack, av);
    if (m_valid || m_in_reset) begin
      check("io_out", io_out, m_data);
      check("out_en", out_en, m_en);
      check("grant_id", grant_id, m_gid);
    end
  endtask

  task automatic core_on_ack(input int k);
    bit reload;
    case (mode)
      1: reload = 1;
      2: reload = ($urandom_range(0, 1) == 1);
      3: reload = 1;
      default: reload = 0;
    endcase
    if (reload) begin
      c_data[k] = DW'($urandom);
      c_en[k]   = (mode == 3) ? EW'(1) : EW'($urandom_range(1, (1 << EW) - 1));
    end else begin
      c_en[k] = '0;
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // then cores react at the falling edge to the ack they just sampled.
  task automatic step();
    int acked;
    acked = m_ack;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
    if (acked >= 0) core_on_ack(acked);
  endtask

  task automatic clear_cores();
    for (int k = 0; k < N; k++) c_en[k] = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int q_grants[$];
    int exp_order[6];
    int acks;
    logic signed [DW-1:0] neg1234;
    logic signed [DW-1:0] d_save;

    for (int k = 0; k < N; k++) begin c_data[k] = '0; c_en[k] = '0; end
    mode = 0;

    // Reset values, then release sequence with every core requesting.
    rst = 1'b1;
    repeat (3) step();
    check("rst_core_rst", core_rst, {N{1'b1}});
    check("rst_io_out", io_out, 0);
    check("rst_grant", grant_id, 0);
    check("rst_valid", out_valid, 0);

    mode = 3;
    for (int k = 0; k < N; k++) begin c_data[k] = DW'($urandom); c_en[k] = EW'(1); end
    rst = 1'b0;
    for (int i = 0; i < 340; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (n == 1)   check("core0_rel_e1", core_rst[0], 0);
      if (n == 7)   check("core1_held_e7", core_rst[1], 1);
      if (n == 8)   check("core1_rel_e8", core_rst[1], 0);
      if (n == 329) check("core47_held_e329", core_rst[47], 1);
      if (n == 330) check("core47_rel_e330", core_rst[47], 0);
      if (n == 330) check("seq_done_e330", seq_done, 0);
      if (n == 331) check("seq_done_e331", seq_done, 1);
    end

    // Fresh reset with idle cores so the pointer starts at core 0.
    mode = 0; clear_cores(); out_ready = 1'b1;
    rst = 1'b1; step(); rst = 1'b0;
    repeat (335) step();

    // Round-robin fairness among cores 0, 3, 47.
    mode = 1;
    foreach (exp_order[i]) exp_order[i] = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 3 : 47;
    c_en[0] = 4'h1;  c_data[0]  = DW'($urandom);
    c_en[3] = 4'h2;  c_data[3]  = DW'($urandom);
    c_en[47] = 4'h8; c_data[47] = DW'($urandom);
    for (int i = 0; i < 13; i++) begin
      step();
      if (out_valid && core_ack != '0) q_grants.push_back(int'(grant_id));
    end
    check("rr_count_ge6", q_grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < q_grants.size(); i++)
      check($sformatf("rr_grant%0d", i), q_grants[i], exp_order[i]);

    mode = 0; clear_cores();
    repeat (3) step();

    // Single beat from core 5.
    neg1234 = -1234;
    c_data[5] = neg1234; c_en[5] = 4'd1;
    acks = 0;
    step();
    check("single_valid", out_valid, 1);
    check("single_io_out", io_out, neg1234);
    check("single_out_en", out_en, 1);
    check("single_grant", grant_id, 5);
    acks += core_ack[5];
    step();
    check("single_done_2cyc", out_valid, 0);
    acks += core_ack[5];
    repeat (4) begin step(); acks += core_ack[5]; end
    check("single_ack_count", acks, 1);

    // Backpressure on core 2.
    out_ready = 1'b0;
    d_save = DW'($urandom);
    c_data[2] = d_save; c_en[2] = 4'hA;
    acks = 0;
    step();
    acks += core_ack[2];
    for (int i = 0; i < 10; i++) begin
      step();
      acks += core_ack[2];
      check("bp_io_out", io_out, d_save);
      check("bp_out_en", out_en, 4'hA);
      check("bp_grant", grant_id, 2);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    check("bp_valid_drop", out_valid, 0);
    acks += core_ack[2];
    check("bp_ack_count", acks, 1);

    // Random traffic and backpressure.
    mode = 2;
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N; k++)
        if (c_en[k] == '0 && $urandom_range(0, 15) == 0) begin
          c_data[k] = DW'($urandom);
          c_en[k]   = EW'($urandom_range(1, (1 << EW) - 1));
        end
      step();
    end

    // Reset while core 9's beat is held.
    mode = 0; clear_cores(); out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    c_data[9] = DW'($urandom); c_en[9] = 4'h3;
    step();
    step();
    check("mid_hold_grant", grant_id, 9);
    check("mid_hold_valid", out_valid, 1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_core_rst", core_rst, {N{1'b1}});
    check("mid_rst_ack", core_ack, 0);
    rst = 1'b0;
    step();
    check("mid_core0_rel", core_rst[0], 0);
    check("mid_core1_held", core_rst[1], 1);
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
